// File: rtl/seven_seg_display_ctrl.sv
// Multi-digit 7-segment driver: hex decode, dp, leading-zero blanking, per-digit blink, global enable.
// Registered output: load visible two edges later, control inputs one edge later; no backpressure.
module seven_seg_display_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      blank_lz,
    input  logic [NUM_DIGITS-1:0]     blink_en,
    input  logic                      enable,
    output logic [8*NUM_DIGITS-1:0]   hex_out
);

    localparam int              CNT_W   = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

    logic [4*NUM_DIGITS-1:0] val_q, val_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    phase_q, phase_d;
    logic [8*NUM_DIGITS-1:0] hex_q, hex_d;
    logic                    wrap;
    logic [NUM_DIGITS-1:0]   lz_sup;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign wrap = (cnt_q == CNT_MAX);

    always_comb begin
        val_d   = load ? value : val_q;
        dp_d    = load ? dp_in : dp_q;
        cnt_d   = wrap ? '0 : cnt_q + 1'b1;
        phase_d = wrap ? ~phase_q : phase_q;
    end

    // Walk from the most significant digit down; a digit is blankable while
    // it and everything above it is zero. Digit 0 always shows.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        lz_sup     = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (val_q[4*i +: 4] == 4'h0);
            lz_sup[i]  = zero_above & (i != 0);
        end
    end

    always_comb begin
        hex_d = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!enable) begin
                hex_d[8*i +: 8] = 8'hFF;
            end else if (phase_q && blink_en[i]) begin
                hex_d[8*i +: 8] = 8'hFF;
            end else if (blank_lz && lz_sup[i]) begin
                hex_d[8*i +: 8] = {~dp_q[i], 7'h7F};
            end else begin
                hex_d[8*i +: 8] = {~dp_q[i], seg_decode(val_q[4*i +: 4])};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            val_q   <= '0;
            dp_q    <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            hex_q   <= '1;
        end else begin
            val_q   <= val_d;
            dp_q    <= dp_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            hex_q   <= hex_d;
        end
    end

    assign hex_out = hex_q;

endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// Randomized and directed bench for seven_seg_display_ctrl against an arithmetic reference model.
module tb_seven_seg_display_ctrl;

    localparam int ND = 4;
    localparam int BD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          load;
    logic [15:0]   value;
    logic [3:0]    dp_in;
    logic          blank_lz;
    logic [3:0]    blink_en;
    logic          enable;
    logic [31:0]   hex_out;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_val;
    logic [3:0]  m_dp;
    int          m_n;
    logic [31:0] exp_q;

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seven_seg_display_ctrl #(.NUM_DIGITS(ND), .BLINK_DIV(BD)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .value    (value),
        .dp_in    (dp_in),
        .blank_lz (blank_lz),
        .blink_en (blink_en),
        .enable   (enable),
        .hex_out  (hex_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_hex(input logic [15:0] v, input logic [3:0] dp, input bit ph,
                                            input bit en, input bit blz, input logic [3:0] ben);
        logic [31:0] r;
        logic [7:0]  b;
        int          nib;
        r = '1;
        for (int i = 0; i < ND; i++) begin
            nib = int'((v >> (4 * i)) & 16'hF);
            if (!en)
                b = 8'hFF;
            else if (ph && ben[i])
                b = 8'hFF;
            else if (blz && i > 0 && (v >> (4 * i)) == 16'h0)
                b = dp[i] ? 8'h7F : 8'hFF;
            else
                b = {~dp[i], seg_tab[nib][6:0]};
            r[8*i +: 8] = b;
        end
        return r;
    endfunction

    // Phase after n edges since reset is floor(n/BD) mod 2; output uses pre-edge state.
    task automatic step(input string tag);
        @(posedge clk);
        exp_q = exp_hex(m_val, m_dp, ((m_n / BD) % 2) == 1, enable, blank_lz, blink_en);
        if (load) begin
            m_val = value;
            m_dp  = dp_in;
        end
        m_n++;
        #1;
        chk(tag, hex_out, exp_q);
    endtask

    task automatic model_reset();
        m_val = '0;
        m_dp  = '0;
        m_n   = 0;
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; value = '0; dp_in = '0;
        blank_lz = 1'b0; blink_en = '0; enable = 1'b1;
        model_reset();
        #12;
        chk("reset_hold", hex_out, 32'hFFFF_FFFF);
        #4 reset = 1'b0;

        step("post_reset");
        chk("post_reset_c0", hex_out, 32'hC0C0_C0C0);

        load = 1'b1; value = 16'h12AF; dp_in = 4'b0000;
        step("ld_12af_e1");
        load = 1'b0;
        step("ld_12af_e2");
        chk("vec_12af", hex_out, 32'hF9A4_888E);

        blank_lz = 1'b1;
        load = 1'b1; value = 16'h0005; step("lz5_e1"); load = 1'b0; step("lz5_e2");
        chk("vec_lz5", hex_out, 32'hFFFF_FF92);
        load = 1'b1; value = 16'h0000; step("lz0_e1"); load = 1'b0; step("lz0_e2");
        chk("vec_lz0", hex_out, 32'hFFFF_FFC0);
        load = 1'b1; dp_in = 4'b0100; step("lzdp_e1"); load = 1'b0; step("lzdp_e2");
        chk("vec_lzdp", hex_out, 32'hFF7F_FFC0);

        blank_lz = 1'b0;
        foreach (value[i]) ;
        for (int k = 0; k < 4; k++) begin
            load = 1'b1;
            value = {4'(4*k+3), 4'(4*k+2), 4'(4*k+1), 4'(4*k)};
            dp_in = 4'(k);
            step("nib_ld");
            load = 1'b0;
            step("nib_show");
        end

        load = 1'b1; value = 16'h1234; dp_in = 4'b0000; step("blink_ld");
        load = 1'b0; blink_en = 4'b0001;
        for (int k = 0; k < 4 * BD; k++) step("blink");

        for (int k = 0; k < 3; k++) begin
            enable = 1'b0;
            step("enable_off");
        end
        chk("enable_off_ff", hex_out, 32'hFFFF_FFFF);
        enable = 1'b1;
        for (int k = 0; k < 2 * BD; k++) step("enable_on");

        for (int g = 0; g < 3 * BD && (m_n % BD) != BD - 1; g++) step("to_wrap");
        load = 1'b1; value = 16'hBEEF; dp_in = 4'b1010;
        step("wrap_ld");
        load = 1'b0;
        for (int k = 0; k < 2 * BD; k++) step("wrap_after");

        #2 reset = 1'b1;
        #1 chk("async_rst", hex_out, 32'hFFFF_FFFF);
        model_reset();
        #1 reset = 1'b0;
        blink_en = 4'b1111;
        for (int k = 0; k < BD; k++) step("rst_restart");
        chk("rst_phase0", hex_out, 32'hC0C0_C0C0);
        step("rst_first_toggle");
        chk("rst_toggle_ff", hex_out, 32'hFFFF_FFFF);

        blink_en = 4'b0000; blank_lz = 1'b1;
        #3 reset = 1'b1;
        model_reset();
        #2 reset = 1'b0;
        step("rst_blz");
        chk("rst_blz_vec", hex_out, 32'hFFFF_FFC0);

        for (int k = 0; k < 400; k++) begin
            load     = ($urandom_range(0, 3) == 0);
            value    = 16'($urandom);
            if ($urandom_range(0, 2) == 0) value = value >> (4 * $urandom_range(1, 3));
            dp_in    = 4'($urandom);
            blank_lz = 1'($urandom);
            blink_en = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'b0000;
            enable   = ($urandom_range(0, 7) != 0);
            step("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
